// File: rtl/button_conditioner.sv
// Five-button conditioner: two-flop synchronizer, tick-based debouncer and per-button press FSM.
// Optional auto-repeat on U and D is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] btn_raw,
  output logic [4:0] level,
  output logic [4:0] pulse
);

  localparam int N  = 5;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: all tick parameters must be at least 1");
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_e;

  // Only U (bit0) and D (bit1) auto-repeat; C, L and R park in HELD.
  localparam logic [N-1:0] REPEAT_MASK = 5'b00011;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] DELAY_SAT   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];
`else
  typedef enum logic {IDLE, HELD} state_e;
`endif

  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  pulse_q, pulse_d;
  logic [DW-1:0] deb_cnt_q [N];
  logic [DW-1:0] deb_cnt_d [N];
  state_e        state_q [N];
  state_e        state_d [N];

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // A level flips only after DEBOUNCE_TICKS consecutive disagreeing ticks.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < N; i++) begin
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_cnt_d[i] = '0;
          level_d[i]   = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      for (int i = 0; i < N; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
        hold_q[i]  <= '0;
`endif
      end
    end else begin
      pulse_q <= pulse_d;
      state_q <= state_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // Hold counter restarts on the IDLE->HELD edge so repeat spacing is measured from the first pulse.
  always_comb begin
    state_d = state_q;
`ifdef BTN_AUTOREPEAT_EN
    hold_d  = hold_q;
`endif
    for (int i = 0; i < N; i++) begin
      if (!level_q[i]) begin
        state_d[i] = IDLE;
`ifdef BTN_AUTOREPEAT_EN
        hold_d[i]  = '0;
`endif
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = HELD;
`ifdef BTN_AUTOREPEAT_EN
            hold_d[i]  = '0;
`endif
          end
`ifdef BTN_AUTOREPEAT_EN
          HELD: begin
            if (tick) begin
              if (REPEAT_MASK[i] && hold_q[i] == DELAY_LAST) begin
                state_d[i] = REPEAT;
                hold_d[i]  = '0;
              end else if (hold_q[i] != DELAY_SAT) begin
                hold_d[i] = hold_q[i] + HW'(1);
              end
            end
          end
          REPEAT: begin
            if (tick) hold_d[i] = (hold_q[i] == PERIOD_LAST) ? '0 : hold_q[i] + HW'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < N; i++) begin
      if (level_q[i]) begin
        case (state_q[i])
          IDLE:    pulse_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          HELD:    pulse_d[i] = tick && REPEAT_MASK[i] && (hold_q[i] == DELAY_LAST);
          REPEAT:  pulse_d[i] = tick && (hold_q[i] == PERIOD_LAST);
`endif
          default: ;
        endcase
      end
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule
